// File: rtl/rx_sampler_bbpd.sv
// Data/edge slicer with an Alexander bang-bang phase detector and a windowed,
// saturating early/late vote accumulator that drives the CDR loop.
module rx_sampler_bbpd #(
  parameter int unsigned IN_WIDTH   = 18,
  parameter int          THRESH     = 0,
  parameter int unsigned WINDOW     = 16,
  parameter int unsigned VOTE_WIDTH = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in,
  input  logic                  data_strobe,
  input  logic                  edge_strobe,
  output logic                  data_bit,
  output logic                  data_valid,
  output logic                  early,
  output logic                  late,
  output logic [VOTE_WIDTH-1:0] vote_sum,
  output logic                  vote_valid,
  output logic                  proto_err
);

  localparam int unsigned CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic signed [IN_WIDTH-1:0] THRESH_S = IN_WIDTH'(THRESH);
  localparam logic [VOTE_WIDTH-1:0] ACC_MAX = {1'b0, {(VOTE_WIDTH-1){1'b1}}};
  localparam logic [VOTE_WIDTH-1:0] ACC_MIN = {1'b1, {(VOTE_WIDTH-1){1'b0}}};

  logic                  e_q;
  logic                  edge_pending_q;
  logic                  d_prev_q;
  logic                  d_prev_valid_q;
  logic [VOTE_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  slice;
  logic                  pd_qual;
  logic                  vote_late;
  logic                  vote_early;
  logic [VOTE_WIDTH-1:0] acc_d;
  logic                  win_done;

  always_comb begin
    slice      = $signed(in) >= THRESH_S;
    // A vote needs a prior data bit, an edge between, and a transition.
    pd_qual    = d_prev_valid_q && edge_pending_q && (d_prev_q != slice);
    vote_late  = data_strobe && pd_qual && (e_q == slice);
    vote_early = data_strobe && pd_qual && (e_q == d_prev_q);
    acc_d      = acc_q;
    if (vote_late && (acc_q != ACC_MAX)) begin
      acc_d = acc_q + VOTE_WIDTH'(1);
    end else if (vote_early && (acc_q != ACC_MIN)) begin
      acc_d = acc_q - VOTE_WIDTH'(1);
    end
    win_done   = data_strobe && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      data_bit       <= 1'b0;
      data_valid     <= 1'b0;
      early          <= 1'b0;
      late           <= 1'b0;
      vote_sum       <= '0;
      vote_valid     <= 1'b0;
      proto_err      <= 1'b0;
      e_q            <= 1'b0;
      edge_pending_q <= 1'b0;
      d_prev_q       <= 1'b0;
      d_prev_valid_q <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
    end else begin
      data_valid <= data_strobe;
      early      <= vote_early;
      late       <= vote_late;
      vote_valid <= win_done;
      if (data_strobe) begin
        // A coincident edge strobe is dropped but still flags the protocol error.
        if (edge_strobe) begin
          proto_err <= 1'b1;
        end
        data_bit       <= slice;
        d_prev_q       <= slice;
        d_prev_valid_q <= 1'b1;
        edge_pending_q <= 1'b0;
        if (win_done) begin
          vote_sum <= acc_d;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (edge_strobe) begin
        if (edge_pending_q) begin
          proto_err <= 1'b1;
        end
        e_q            <= slice;
        edge_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_sampler_bbpd.sv
// Bench for rx_sampler_bbpd: three configurations share one stimulus stream and
// are compared every cycle against an integer reference model.
module tb_rx_sampler_bbpd;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] din = '0;
  logic        ds = 1'b0;
  logic        es = 1'b0;

  logic [2:0] db, dv, ea, la, vv, pe;
  logic [7:0] vs_o [3];
  logic [7:0] vs_a, vs_b;
  logic [3:0] vs_c;

  always #5 clk_sys = ~clk_sys;

  rx_sampler_bbpd u_def (
    .clk_sys(clk_sys), .rst(rst), .in(din), .data_strobe(ds), .edge_strobe(es),
    .data_bit(db[0]), .data_valid(dv[0]), .early(ea[0]), .late(la[0]),
    .vote_sum(vs_a), .vote_valid(vv[0]), .proto_err(pe[0])
  );

  rx_sampler_bbpd #(.THRESH(5)) u_t5 (
    .clk_sys(clk_sys), .rst(rst), .in(din), .data_strobe(ds), .edge_strobe(es),
    .data_bit(db[1]), .data_valid(dv[1]), .early(ea[1]), .late(la[1]),
    .vote_sum(vs_b), .vote_valid(vv[1]), .proto_err(pe[1])
  );

  rx_sampler_bbpd #(.VOTE_WIDTH(4)) u_v4 (
    .clk_sys(clk_sys), .rst(rst), .in(din), .data_strobe(ds), .edge_strobe(es),
    .data_bit(db[2]), .data_valid(dv[2]), .early(ea[2]), .late(la[2]),
    .vote_sum(vs_c), .vote_valid(vv[2]), .proto_err(pe[2])
  );

  assign vs_o[0] = vs_a;
  assign vs_o[1] = vs_b;
  assign vs_o[2] = {4'b0, vs_c};

  int tests = 0;
  int fails = 0;
  bit cur = 1'b0;

  // Reference model, one slot per configuration.
  int thr [3] = '{0, 5, 0};
  int vw  [3] = '{8, 8, 4};
  int m_db[3], m_pe[3], m_vs[3], m_e[3], m_pend[3], m_dp[3], m_dpv[3], m_acc[3], m_cnt[3];
  int x_dv[3], x_ea[3], x_la[3], x_vv[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_db[k] = 0; m_pe[k] = 0; m_vs[k] = 0; m_e[k] = 0; m_pend[k] = 0;
      m_dp[k] = 0; m_dpv[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
      x_dv[k] = 0; x_ea[k] = 0; x_la[k] = 0; x_vv[k] = 0;
    end
  endtask

  task automatic model_step(bit sd, bit se, int v);
    for (int k = 0; k < 3; k++) begin
      int s;
      int vote;
      int hi;
      int lo;
      s = (v >= thr[k]) ? 1 : 0;
      hi = (1 << (vw[k] - 1)) - 1;
      lo = -(1 << (vw[k] - 1));
      x_dv[k] = 0; x_ea[k] = 0; x_la[k] = 0; x_vv[k] = 0;
      if (sd) begin
        x_dv[k] = 1;
        m_db[k] = s;
        if (se) m_pe[k] = 1;
        vote = 0;
        if (m_dpv[k] == 1 && m_pend[k] == 1 && m_dp[k] != s)
          vote = (m_e[k] == m_dp[k]) ? -1 : 1;
        x_ea[k] = (vote < 0) ? 1 : 0;
        x_la[k] = (vote > 0) ? 1 : 0;
        m_acc[k] = m_acc[k] + vote;
        if (m_acc[k] > hi) m_acc[k] = hi;
        if (m_acc[k] < lo) m_acc[k] = lo;
        m_cnt[k]++;
        if (m_cnt[k] == 16) begin
          m_vs[k] = m_acc[k];
          x_vv[k] = 1;
          m_acc[k] = 0;
          m_cnt[k] = 0;
        end
        m_dp[k] = s; m_dpv[k] = 1; m_pend[k] = 0;
      end else if (se) begin
        if (m_pend[k] == 1) m_pe[k] = 1;
        m_e[k] = s;
        m_pend[k] = 1;
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("%s.u%0d.data_bit", tag, k), 32'(db[k]), 32'(m_db[k]));
      cmp($sformatf("%s.u%0d.data_valid", tag, k), 32'(dv[k]), 32'(x_dv[k]));
      cmp($sformatf("%s.u%0d.early", tag, k), 32'(ea[k]), 32'(x_ea[k]));
      cmp($sformatf("%s.u%0d.late", tag, k), 32'(la[k]), 32'(x_la[k]));
      cmp($sformatf("%s.u%0d.vote_valid", tag, k), 32'(vv[k]), 32'(x_vv[k]));
      cmp($sformatf("%s.u%0d.proto_err", tag, k), 32'(pe[k]), 32'(m_pe[k]));
      cmp($sformatf("%s.u%0d.vote_sum", tag, k), 32'(vs_o[k]),
          32'(m_vs[k] & ((1 << vw[k]) - 1)));
    end
  endtask

  task automatic step(bit sd, bit se, int v, string tag);
    @(negedge clk_sys);
    ds = sd;
    es = se;
    din = v[17:0];
    model_step(sd, se, v);
    @(posedge clk_sys);
    #1;
    check_all(tag);
  endtask

  function automatic int lvl(bit b);
    return b ? 100 : -100;
  endfunction

  task automatic data(bit b, string tag);
    step(1'b1, 1'b0, lvl(b), tag);
    cur = b;
  endtask

  task automatic edge_s(bit b, string tag);
    step(1'b0, 1'b1, lvl(b), tag);
  endtask

  task automatic late_v();
    edge_s(!cur, "late_e");
    data(!cur, "late_d");
  endtask

  task automatic early_v();
    edge_s(cur, "early_e");
    data(!cur, "early_d");
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1;
    ds = 1'b0;
    es = 1'b0;
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
    cur = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_sys);
    rst = 1'b0;

    // Slicer boundaries and one-cycle data latency.
    step(1'b1, 1'b0, 0, "sl_zero");
    cmp("sl_zero_def", 32'(db[0]), 32'd1);
    cmp("sl_zero_t5", 32'(db[1]), 32'd0);
    step(1'b0, 1'b0, 0, "sl_idle");
    step(1'b1, 1'b0, -1, "sl_m1");
    step(1'b1, 1'b0, 131071, "sl_max");
    step(1'b1, 1'b0, -131072, "sl_min");
    step(1'b1, 1'b0, 4, "sl_4");
    cmp("sl_4_t5", 32'(db[1]), 32'd0);
    step(1'b1, 1'b0, 5, "sl_5");
    cmp("sl_5_t5", 32'(db[1]), 32'd1);

    // Alexander PD cases.
    do_reset();
    data(1'b0, "pd_d0");
    edge_s(1'b0, "pd_e0");
    data(1'b1, "pd_d1");
    cmp("pd_early", 32'(ea[0]), 32'd1);
    edge_s(1'b0, "pd_e0b");
    data(1'b0, "pd_d0b");
    cmp("pd_late", 32'(la[0]), 32'd1);
    data(1'b1, "pd_noedge");
    cmp("pd_noedge_err", 32'(pe[0]), 32'd0);
    edge_s(1'b1, "pd_e1");
    data(1'b1, "pd_same");

    // Window: 10 late, 3 early, 2 idle votes after a priming strobe.
    do_reset();
    data(1'b0, "w_prime");
    for (int i = 0; i < 10; i++) late_v();
    for (int i = 0; i < 3; i++) early_v();
    data(cur, "w_nv1");
    data(cur, "w_nv2");
    cmp("win_plus7_valid", 32'(vv[0]), 32'd1);
    cmp("win_plus7", 32'(vs_o[0]), 32'h07);
    for (int i = 0; i < 8; i++) begin
      early_v();
      data(cur, "w_alt_nv");
    end
    cmp("win_minus8", 32'(vs_o[0]), 32'hF8);
    cmp("win_minus8_v4", 32'(vs_o[2]), 32'h8);

    // Saturation windows.
    for (int i = 0; i < 16; i++) late_v();
    cmp("sat_pos_def", 32'(vs_o[0]), 32'h10);
    cmp("sat_pos_v4", 32'(vs_o[2]), 32'h7);
    for (int i = 0; i < 16; i++) early_v();
    cmp("sat_neg_def", 32'(vs_o[0]), 32'hF0);
    cmp("sat_neg_v4", 32'(vs_o[2]), 32'h8);

    // Protocol errors.
    step(1'b1, 1'b1, lvl(1'b1), "pe_both");
    cur = 1'b1;
    cmp("pe_both_flag", 32'(pe[0]), 32'd1);
    data(1'b0, "pe_after_both");
    cmp("pe_no_vote", 32'(ea[0] | la[0]), 32'd0);
    edge_s(1'b0, "pe_e_first");
    edge_s(1'b1, "pe_e_second");
    data(1'b1, "pe_second_used");
    cmp("pe_second_late", 32'(la[0]), 32'd1);
    step(1'b0, 1'b0, 0, "pe_sticky");
    cmp("pe_sticky_flag", 32'(pe[0]), 32'd1);

    // Async reset mid-cycle with strobes active.
    data(1'b1, "ar_pre");
    ds = 1'b1;
    es = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_sys);
    rst = 1'b0;
    ds = 1'b0;
    es = 1'b0;
    data(1'b1, "ar_first");
    edge_s(1'b0, "ar_e");
    data(1'b0, "ar_second");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      int v;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 12)) - 4;
      else v = int'($urandom_range(0, 262143)) - 131072;
      step(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, v, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
